// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding, counter sizing
// and parameter legality checks.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_HOLD,
        S_RELEASE,
        S_RUN
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    // A hold of zero cycles would have to release stage 0 in the cycle S_HOLD is entered.
    function automatic bit params_legal(input int hold, input int stages, input int gap);
        return (hold >= 1) && (stages >= 1) && (stages <= 8) && (gap >= 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release sequencer gated by a synchronized PLL lock.
// Optional macro RESET_SEQ_LOCK_LOSS_EN: lock loss after qualification restarts the sequence.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int STAGES      = 3,
    parameter int STAGE_GAP   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              soft_rst_req,
    output logic [STAGES-1:0] stage_rst_n,
    output logic              reset_done,
    output logic              soft_rst_ack
);

    localparam int unsigned CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);

    if (!params_legal(HOLD_CYCLES, STAGES, STAGE_GAP)) begin : g_param_check
        $error("reset_sequencer: illegal HOLD_CYCLES/STAGES/STAGE_GAP");
    end

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [STAGES-1:0] stage_nxt, stage_adv;
    logic              done_nxt, ack_nxt;
    logic              lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_RESET;
            cnt          <= '0;
            stage_rst_n  <= '0;
            reset_done   <= 1'b0;
            soft_rst_ack <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            stage_rst_n  <= stage_nxt;
            reset_done   <= done_nxt;
            soft_rst_ack <= ack_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (&cnt) ? cnt : cnt + 1'b1;
        stage_nxt = stage_rst_n;
        done_nxt  = reset_done;
        ack_nxt   = 1'b0;
        // Releases are thermometer-coded: each step sets the next higher bit.
        stage_adv = (stage_rst_n << 1) | STAGES'(1'b1);

        case (state)
            S_RESET: begin
                state_nxt = S_WAIT_LOCK;
                cnt_nxt   = '0;
            end
            S_WAIT_LOCK: begin
                cnt_nxt = '0;
                if (lock_s) state_nxt = S_HOLD;
            end
            S_HOLD, S_RELEASE: begin
                if (cnt == ((state == S_HOLD) ? HOLD_LAST : GAP_LAST)) begin
                    stage_nxt = stage_adv;
                    cnt_nxt   = '0;
                    if (&stage_adv) begin
                        state_nxt = S_RUN;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = S_RELEASE;
                    end
                end
            end
            S_RUN: begin
                cnt_nxt = '0;
                if (soft_rst_req) begin
                    state_nxt = S_HOLD;
                    stage_nxt = '0;
                    done_nxt  = 1'b0;
                    ack_nxt   = 1'b1;
                end
            end
            default: begin
                state_nxt = S_RESET;
                cnt_nxt   = '0;
                stage_nxt = '0;
                done_nxt  = 1'b0;
            end
        endcase

`ifdef RESET_SEQ_LOCK_LOSS_EN
        // Lock loss overrides everything above, including a soft request in S_RUN.
        if ((state == S_HOLD || state == S_RELEASE || state == S_RUN) && !lock_s) begin
            state_nxt = S_WAIT_LOCK;
            cnt_nxt   = '0;
            stage_nxt = '0;
            done_nxt  = 1'b0;
            ack_nxt   = 1'b0;
        end
`endif
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer; expectations come from a release-time model.
module tb_reset_sequencer;

    localparam int H = 16;
    localparam int S = 3;
    localparam int G = 4;
`ifdef RESET_SEQ_LOCK_LOSS_EN
    localparam bit LL = 1'b1;
`else
    localparam bit LL = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         pll_locked = 1'b0;
    logic         soft_rst_req = 1'b0;
    logic [S-1:0] stage_rst_n;
    logic         reset_done;
    logic         soft_rst_ack;

    reset_sequencer #(.HOLD_CYCLES(H), .STAGES(S), .STAGE_GAP(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (stage_rst_n),
        .reset_done   (reset_done),
        .soft_rst_ack (soft_rst_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int c     = 0;

    // Model: stage k is released once the cycle count reaches t_hold + H + k*G.
    bit m_out, m_act, m_ack, m_s1, m_s2;
    int t_hold;

    function bit rel_at(input int cy, input int k);
        return m_act && (cy >= t_hold + H + k * G);
    endfunction

    task model_clear();
        m_out = 1'b0; m_act = 1'b0; m_ack = 1'b0;
        m_s1 = 1'b0; m_s2 = 1'b0; t_hold = 0;
    endtask

    task model_edge();
        bit lock_pre, done_prev;
        c++;
        if (!rst_n) begin
            model_clear();
            return;
        end
        lock_pre  = m_s2;
        done_prev = rel_at(c - 1, S - 1);
        m_ack     = 1'b0;
        if (!m_out) begin
            m_out = 1'b1;
        end else if (!m_act) begin
            if (lock_pre) begin
                m_act  = 1'b1;
                t_hold = c;
            end
        end else if (LL && !lock_pre) begin
            m_act = 1'b0;
        end else if (done_prev && soft_rst_req) begin
            t_hold = c;
            m_ack  = 1'b1;
        end
        m_s2 = m_s1;
        m_s1 = pll_locked;
    endtask

    task check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    task check_outputs();
        logic [S-1:0] exp_stage;
        for (int k = 0; k < S; k++) exp_stage[k] = rel_at(c, k);
        check("stage_rst_n", 32'(stage_rst_n), 32'(exp_stage));
        check("reset_done", 32'(reset_done), 32'(rel_at(c, S - 1)));
        check("soft_rst_ack", 32'(soft_rst_ack), 32'(m_ack));
    endtask

    task cyc(input bit r, input bit p, input bit s);
        @(negedge clk);
        rst_n        = r;
        pll_locked   = p;
        soft_rst_req = s;
        if (!r) model_clear();
        @(posedge clk);
        model_edge();
        #1 check_outputs();
    endtask

    // Reset asserted between clock edges; outputs must clear without an edge.
    task async_rst();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_clear();
        #1 check_outputs();
    endtask

    initial begin
        int len;
        bit p;
        model_clear();

        repeat (3) cyc(0, 1, 0);
        repeat (30) cyc(1, 1, 0);

        cyc(1, 1, 1);
        repeat (30) cyc(1, 1, 0);

        cyc(1, 1, 1);
        repeat (5) cyc(1, 1, 0);
        cyc(1, 1, 1);
        repeat (25) cyc(1, 1, 0);

        cyc(1, 1, 1);
        while (c < t_hold + 18) cyc(1, 1, 0);
        async_rst();
        repeat (2) cyc(0, 1, 0);
        repeat (30) cyc(1, 1, 0);

        repeat (2) cyc(0, 0, 0);
        repeat (50) cyc(1, 0, 0);
        repeat (30) cyc(1, 1, 0);

        repeat (4) cyc(1, 0, 0);
        repeat (35) cyc(1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            p   = ($urandom_range(0, 4) != 0);
            len = $urandom_range(1, 30);
            repeat (len) cyc(1, p, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 9) == 0) begin
                async_rst();
                cyc(0, p, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: cycles all stage resets stay asserted after lock qualifies, before stage 0 releases.
REQ-002 Parameter STAGES, default 3: number of staged reset outputs; legal range 1..8.
REQ-003 Parameter STAGE_GAP, default 4: cycles between consecutive stage releases; legal range at least 1.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low; driven by the upstream reset synchronizer, so assertion is asynchronous and deassertion is clk-synchronous.
REQ-006 pll_locked  input  1  clock-source lock indicator, asynchronous to clk.
REQ-007 soft_rst_req  input  1  single-cycle soft-reset request pulse.
REQ-008 stage_rst_n  output  STAGES  per-domain active-low resets; bit 0 releases first.
REQ-009 reset_done  output  1  high when all stages are released.
REQ-010 soft_rst_ack  output  1  one-cycle pulse acknowledging an accepted soft reset.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchronizer; lock_s lags pll_locked by 2 cycles.
REQ-012 FSM states SHALL be S_RESET, S_WAIT_LOCK, S_HOLD, S_RELEASE and S_RUN.
REQ-013 S_RESET SHALL move to S_WAIT_LOCK on the first clk edge with rst_n high.
REQ-014 S_WAIT_LOCK SHALL move to S_HOLD, clearing the counter, on the first edge with lock_s=1.
REQ-015 With first S_HOLD cycle T, stage_rst_n[k] SHALL go high at cycle T+HOLD_CYCLES+k*STAGE_GAP.
REQ-016 reset_done SHALL go high in the same cycle as stage_rst_n[STAGES-1], with the FSM entering S_RUN.
REQ-017 Released stage bits SHALL stay high until the next reset event; no bit may release out of order.
REQ-018 soft_rst_req SHALL be accepted only in S_RUN; in all other states it is ignored and produces no ack.
REQ-019 An accepted request SHALL, on the next cycle, drive stage_rst_n to all zeros, reset_done to 0, soft_rst_ack to 1 for one cycle, and enter S_HOLD without re-checking lock.
REQ-020 Counter width SHALL be $clog2(max(HOLD_CYCLES,STAGE_GAP)+1); the counter saturates and never wraps.
REQ-021 All outputs SHALL be registered with no combinational path from input to output.
REQ-022 If STAGES=1, the sequencer SHALL skip gap timing and assert reset_done with stage 0.

Reset
REQ-023 While rst_n=0: state S_RESET, stage_rst_n all 0, reset_done 0, soft_rst_ack 0, counter 0, synchronizer flops 0.
REQ-024 Asserting rst_n mid-sequence, in any state, SHALL force the REQ-023 values immediately, without waiting for clk.

Configuration
REQ-025 Macro RESET_SEQ_LOCK_LOSS_EN defined: lock_s=0 in S_HOLD, S_RELEASE or S_RUN SHALL drive all stage_rst_n low and reset_done low on the next cycle, and enter S_WAIT_LOCK.
REQ-026 Macro RESET_SEQ_LOCK_LOSS_EN undefined: lock_s SHALL be ignored outside S_WAIT_LOCK.
REQ-027 Lock loss in the same cycle as an accepted soft request (macro defined) SHALL take priority; no ack is issued.

Structure
REQ-028 Package reset_seq_pkg SHALL hold the state encoding, the counter-width function and the parameter legality checks.
REQ-029 The lock synchronizer SHALL be a sub-module named sync_2ff, reset by rst_n.

Verification (HOLD_CYCLES=16, STAGES=3, STAGE_GAP=4)
REQ-030 pll_locked high throughout, rst_n released at cycle 0 -> S_HOLD entered at T; stage_rst_n goes 001 at T+16, 011 at T+20, 111 at T+24; reset_done=1 at T+24.
REQ-031 pll_locked held low for 50 cycles after rst_n release -> stage_rst_n=000 throughout; S_HOLD is entered 2-3 cycles after pll_locked rises.
REQ-032 soft_rst_req pulse in S_RUN -> next cycle stage_rst_n=000, soft_rst_ack=1 for exactly 1 cycle; full release sequence completes 24 cycles after re-entering S_HOLD.
REQ-033 soft_rst_req pulse during S_HOLD -> no ack and no change to release timing.
REQ-034 rst_n pulsed low at T+18, between edges -> outputs clear without a clk edge; the sequence restarts from S_RESET.
REQ-035 Macro defined, pll_locked dropped in S_RUN -> stage_rst_n=000 within 3 cycles; the sequence repeats after relock. Macro undefined, same stimulus -> outputs unchanged.
